// File: rtl/apb_pkg.sv
// Shared APB widths, payload types and the arbiter state encoding.
// No ports; imported by the interface, the arbiter and the bench.
package apb_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SETUP,
        ARB_ACCESS
    } arb_state_t;

endpackage

// File: rtl/apb_dpmem_arbiter_if.sv
// APB bus between the arbiter (master) and the memory slave port.
// Signals: PSEL PENABLE PWRITE PADDR PWDATA PSTRB / PRDATA PREADY PSLVERR.
interface apb_dpmem_arbiter_if;
    import apb_pkg::*;

    logic  PSEL;
    logic  PENABLE;
    logic  PWRITE;
    addr_t PADDR;
    data_t PWDATA;
    strb_t PSTRB;
    data_t PRDATA;
    logic  PREADY;
    logic  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE,
        output PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE,
        input  PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first req bit strictly after ptr.
// Ports: req, ptr in; gnt (one-hot), idx (grant index), any out.
module apb_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    always_comb begin
        int         j;
        logic [IDX_W-1:0] jj;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        // Scan ptr+1 .. ptr+NUM_REQ so ptr itself is visited last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDX_W'(j);
            if (!any && req[jj]) begin
                any     = 1'b1;
                gnt[jj] = 1'b1;
                idx     = jj;
            end
        end
    end

endmodule

// File: rtl/apb_dpmem_arbiter.sv
// APB master sharing one memory slave port among NUM_REQ requesters.
// Ports: PCLK, PRESETn; req_valid/write/addr/wdata/strb in, req_ready out;
// rsp_valid/rsp_rdata/rsp_err out; apb (master modport of the APB bus).
// Option: define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module apb_dpmem_arbiter
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0] req_strb,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output data_t                        rsp_rdata,
    output logic                         rsp_err,
    apb_dpmem_arbiter_if.master          apb
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic psel_d, penable_d, pwrite_d;
    addr_t paddr_d;
    data_t pwdata_d;
    strb_t pstrb_d;
    logic [NUM_REQ-1:0] ready_d, rsp_valid_d;
    data_t rdata_d;
    logic err_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic gnt_any;
    logic grant_go;
    logic timeout;
    logic [NUM_REQ-1:0] owner_hot;

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign owner_hot = NUM_REQ'(1) << owner_q;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    // Zero in every non-ACCESS cycle, so it starts at 0 on ACCESS entry.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
        end else if (state_q != ARB_ACCESS) begin
            cnt_q <= '0;
        end else if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == ARB_ACCESS) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // Stalled transfers wait forever in this build.
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        psel_d      = apb.PSEL;
        penable_d   = apb.PENABLE;
        pwrite_d    = apb.PWRITE;
        paddr_d     = apb.PADDR;
        pwdata_d    = apb.PWDATA;
        pstrb_d     = apb.PSTRB;
        ready_d     = '0;
        rsp_valid_d = '0;
        rdata_d     = rsp_rdata;
        err_d       = rsp_err;
        grant_go    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                grant_go = gnt_any;
            end
            ARB_SETUP: begin
                penable_d = 1'b1;
                state_d   = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (apb.PREADY) begin
                    rsp_valid_d = owner_hot;
                    rdata_d     = apb.PWRITE ? '0 : apb.PRDATA;
                    err_d       = apb.PSLVERR;
                    if (gnt_any) begin
                        grant_go = 1'b1;
                    end else begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        state_d   = ARB_IDLE;
                    end
                end else if (timeout) begin
                    rsp_valid_d = owner_hot;
                    rdata_d     = '0;
                    err_d       = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // Shared by IDLE and back-to-back ACCESS completion.
        if (grant_go) begin
            ptr_d     = gnt_idx;
            owner_d   = gnt_idx;
            ready_d   = gnt;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = req_write[gnt_idx];
            paddr_d   = req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            pwdata_d  = req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            pstrb_d   = req_write[gnt_idx] ?
                        req_strb[int'(gnt_idx)*STRB_WIDTH +: STRB_WIDTH] : '0;
            state_d   = ARB_SETUP;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            apb.PSTRB   <= '0;
            req_ready   <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            apb.PSEL    <= psel_d;
            apb.PENABLE <= penable_d;
            apb.PWRITE  <= pwrite_d;
            apb.PADDR   <= paddr_d;
            apb.PWDATA  <= pwdata_d;
            apb.PSTRB   <= pstrb_d;
            req_ready   <= ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rdata_d;
            rsp_err     <= err_d;
        end
    end

endmodule
